// File: rtl/sram_pkg.sv
// sram_pkg: settings shared by the SRAM request controller, its response FIFO
// and the sram_wrapper it drives.
//   SRAM_ADDR_W / SRAM_DATA_W / SRAM_RD_LAT : geometry and read latency of the macro
//   sram_req_t                              : one client command {wmode, addr, wdata}
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 10;
  localparam int unsigned SRAM_DATA_W = 8;
  localparam int unsigned SRAM_RD_LAT = 2;

  typedef struct packed {
    logic                   wmode;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: DATA_W x DEPTH synchronous FIFO that holds read responses.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   push_i, wdata_i    : write side
//   pop_i              : read side; rdata_o is the head entry, 0 when empty
//   full_o, empty_o    : status
//   count_o            : occupancy, 0..DEPTH
// DEPTH must be a power of 2 and at least 2.
module sram_rsp_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one wrap bit above the index so full and empty differ.
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i && !full_o) wr_d = wr_q + 1'b1;
    if (pop_i && !empty_o) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: an entry is only visible after it was written.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl: request-side controller for the RW0 port of one sram_wrapper.
//   RW0_clk, RW0_rst_n              : shared clock, asynchronous active-low reset
//   req_valid/req_ready             : command handshake
//   req_wmode, req_addr, req_wdata  : command (1 = write)
//   rsp_valid/rsp_ready, rsp_rdata  : in-order read responses
//   RW0_addr/wdata/en/wmode         : to sram_wrapper (wdata is registered there)
//   RW0_rdata                       : from sram_wrapper, RD_LAT after the en sample edge
//   busy                            : reads in flight or responses queued
// A command accepted in cycle N reaches RW0 in N+1; a read's data lands in the
// response FIFO after RD_LAT more cycles. A credit gate keeps every read that
// has been accepted guaranteed a FIFO slot, so the FIFO never overflows.
module sram_rw_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_DATA_W,
  parameter int unsigned RD_LAT    = SRAM_RD_LAT,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              RW0_clk,
  input  logic              RW0_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wmode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic              RW0_en,
  output logic              RW0_wmode,
  input  logic [DATA_W-1:0] RW0_rdata,
  output logic              busy
);

  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(RSP_DEPTH);

  logic              accept, rd_accept, push, pop;
  logic              en_q, en_d, wmode_q, wmode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [CW:0]       credits_used;

  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_wmode;

  // The wrapper registers wdata itself, so it is presented in the accept cycle.
  assign RW0_wdata = req_wdata;
  assign RW0_en    = en_q;
  assign RW0_addr  = addr_q;
  assign RW0_wmode = wmode_q;

  // Gate uses registered state only; a pop frees its credit one cycle later.
  assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign req_ready    = (credits_used < DEPTH_C);

  // Tail of the marker pipe lines up with RW0_rdata for that read.
  assign push = pipe_q[RD_LAT-1];
  assign pop  = rsp_valid & rsp_ready;

  assign busy = (inflight_q != '0) | (fifo_count != '0);

  always_comb begin
    en_d       = accept;
    addr_d     = accept ? req_addr  : addr_q;
    wmode_d    = accept ? req_wmode : wmode_q;
    pipe_d     = pipe_q << 1;
    pipe_d[0]  = en_q & ~wmode_q;
    inflight_d = inflight_q + CW'(rd_accept) - CW'(push);
  end

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      en_q       <= 1'b0;
      addr_q     <= '0;
      wmode_q    <= 1'b0;
      pipe_q     <= '0;
      inflight_q <= '0;
    end else begin
      en_q       <= en_d;
      addr_q     <= addr_d;
      wmode_q    <= wmode_d;
      pipe_q     <= pipe_d;
      inflight_q <= inflight_d;
    end
  end

  sram_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (RW0_clk),
    .rst_ni  (RW0_rst_n),
    .push_i  (push & ~fifo_full),
    .wdata_i (RW0_rdata),
    .pop_i   (pop),
    .rdata_o (rsp_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rsp_valid = ~fifo_empty;

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Directed bench for sram_rw_ctrl with a small behavioural model of
// sram_wrapper + SRAM1RW1024x8 (wdata registered, 2-cycle read latency).
module tb_sram_rw_ctrl;
  import sram_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_wmode = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, RW0_en, RW0_wmode, busy;
  logic [DW-1:0] rsp_rdata, RW0_wdata, RW0_rdata;
  logic [AW-1:0] RW0_addr;

  always #5 clk = ~clk;

  sram_rw_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .RSP_DEPTH(4)) dut (
    .RW0_clk(clk), .RW0_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wmode(req_wmode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .RW0_addr(RW0_addr), .RW0_wdata(RW0_wdata), .RW0_en(RW0_en),
    .RW0_wmode(RW0_wmode), .RW0_rdata(RW0_rdata), .busy(busy)
  );

  // Wrapper + macro model.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] wdq = '0, r1 = '0, r2 = '0;
  assign RW0_rdata = r2;
  always @(posedge clk) begin
    wdq <= RW0_wdata;
    if (RW0_en) begin
      if (RW0_wmode) mem[RW0_addr] <= wdq;
      else           r1 <= mem[RW0_addr];
    end
    r2 <= r1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  // Drive inputs just after the edge, then wait to mid-cycle for sampling.
  task automatic cyc(input logic v, input logic wm, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic rr);
    @(posedge clk);
    #1;
    req_valid = v; req_wmode = wm; req_addr = a; req_wdata = d; rsp_ready = rr;
    #4;
  endtask

  typedef struct {
    logic [3:0]    ib;   // {rst_n, valid, wmode, rsp_ready}
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [4:0]    ob;   // {req_ready, RW0_en, RW0_wmode, rsp_valid, busy}
    logic [AW-1:0] oa;
    logic [DW-1:0] od;   // RW0_wdata
    logic [DW-1:0] rd;   // rsp_rdata
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ib, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [4:0] ob,
                              input logic [AW-1:0] oa, input logic [DW-1:0] od,
                              input logic [DW-1:0] rd);
    vec_t t;
    t.ib = ib; t.a = a; t.d = d; t.ob = ob; t.oa = oa; t.od = od; t.rd = rd;
    return t;
  endfunction

  vec_t tbl[$];
  logic [DW-1:0] got[$];
  int acc;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset, single write/read of 0x3A5.
    tbl.push_back(mk(4'b0001, 10'h000, 8'h00, 5'b10000, 10'h000, 8'h00, 8'h00));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b10000, 10'h000, 8'h00, 8'h00));
    tbl.push_back(mk(4'b1111, 10'h3A5, 8'hC3, 5'b10000, 10'h000, 8'hC3, 8'h00));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b11100, 10'h3A5, 8'h00, 8'h00));
    tbl.push_back(mk(4'b1101, 10'h3A5, 8'h00, 5'b10100, 10'h3A5, 8'h00, 8'h00));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b11001, 10'h3A5, 8'h00, 8'h00));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b10001, 10'h3A5, 8'h00, 8'h00));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b10001, 10'h3A5, 8'h00, 8'h00));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b10011, 10'h3A5, 8'h00, 8'hC3));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b10000, 10'h3A5, 8'h00, 8'h00));
    // Writes 0..3, then four back-to-back reads.
    tbl.push_back(mk(4'b1111, 10'h000, 8'h10, 5'b10000, 10'h3A5, 8'h10, 8'h00));
    tbl.push_back(mk(4'b1111, 10'h001, 8'h11, 5'b11100, 10'h000, 8'h11, 8'h00));
    tbl.push_back(mk(4'b1111, 10'h002, 8'h12, 5'b11100, 10'h001, 8'h12, 8'h00));
    tbl.push_back(mk(4'b1111, 10'h003, 8'h13, 5'b11100, 10'h002, 8'h13, 8'h00));
    tbl.push_back(mk(4'b1101, 10'h000, 8'h00, 5'b11100, 10'h003, 8'h00, 8'h00));
    tbl.push_back(mk(4'b1101, 10'h001, 8'h00, 5'b11001, 10'h000, 8'h00, 8'h00));
    tbl.push_back(mk(4'b1101, 10'h002, 8'h00, 5'b11001, 10'h001, 8'h00, 8'h00));
    tbl.push_back(mk(4'b1101, 10'h003, 8'h00, 5'b11001, 10'h002, 8'h00, 8'h00));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b01011, 10'h003, 8'h00, 8'h10));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b10011, 10'h003, 8'h00, 8'h11));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b10011, 10'h003, 8'h00, 8'h12));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b10011, 10'h003, 8'h00, 8'h13));
    tbl.push_back(mk(4'b1001, 10'h000, 8'h00, 5'b10000, 10'h003, 8'h00, 8'h00));

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst_n     = tbl[i].ib[3];
      req_valid = tbl[i].ib[2];
      req_wmode = tbl[i].ib[1];
      rsp_ready = tbl[i].ib[0];
      req_addr  = tbl[i].a;
      req_wdata = tbl[i].d;
      #4;
      chk($sformatf("row%0d.req_ready", i), 32'(req_ready), 32'(tbl[i].ob[4]));
      chk($sformatf("row%0d.RW0_en",    i), 32'(RW0_en),    32'(tbl[i].ob[3]));
      chk($sformatf("row%0d.RW0_wmode", i), 32'(RW0_wmode), 32'(tbl[i].ob[2]));
      chk($sformatf("row%0d.rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].ob[1]));
      chk($sformatf("row%0d.busy",      i), 32'(busy),      32'(tbl[i].ob[0]));
      chk($sformatf("row%0d.RW0_addr",  i), 32'(RW0_addr),  32'(tbl[i].oa));
      chk($sformatf("row%0d.RW0_wdata", i), 32'(RW0_wdata), 32'(tbl[i].od));
      chk($sformatf("row%0d.rsp_rdata", i), 32'(rsp_rdata), 32'(tbl[i].rd));
    end

    // Back-pressure: only RSP_DEPTH reads fit, then drain in order.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, AW'(acc), 8'h00, 1'b0);
      if (req_ready) acc++;
    end
    chk("bp.accepted", 32'(acc), 32'd4);
    cyc(1'b0, 1'b0, '0, '0, 1'b0);
    chk("bp.full_ready", 32'(req_ready), 32'd0);
    chk("bp.full_valid", 32'(rsp_valid), 32'd1);
    chk("bp.full_busy",  32'(busy),      32'd1);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    chk("bp.d0_ready", 32'(req_ready), 32'd0);
    chk("bp.d0_data",  32'(rsp_rdata), 32'h10);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    chk("bp.d1_ready", 32'(req_ready), 32'd1);
    chk("bp.d1_data",  32'(rsp_rdata), 32'h11);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    chk("bp.d2_data",  32'(rsp_rdata), 32'h12);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    chk("bp.d3_data",  32'(rsp_rdata), 32'h13);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    chk("bp.drained_valid", 32'(rsp_valid), 32'd0);
    chk("bp.drained_busy",  32'(busy),      32'd0);

    // Reset with two reads in flight.
    cyc(1'b1, 1'b0, 10'h000, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 10'h001, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    chk("rst.en_before", 32'(RW0_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst.en_async",  32'(RW0_en),    32'd0);
    chk("rst.busy",      32'(busy),      32'd0);
    chk("rst.ready",     32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #4;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst.post%0d_valid", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("rst.post%0d_busy",  i), 32'(busy),      32'd0);
      cyc(1'b0, 1'b0, '0, '0, 1'b1);
    end

    // Address extremes must not alias.
    cyc(1'b1, 1'b1, 10'h3FF, 8'hAA, 1'b1);
    cyc(1'b1, 1'b1, 10'h000, 8'h55, 1'b1);
    chk("edge.addr_hi", 32'(RW0_addr), 32'h3FF);
    chk("edge.en_hi",   32'(RW0_en & RW0_wmode), 32'd1);
    cyc(1'b1, 1'b0, 10'h3FF, 8'h00, 1'b1);
    chk("edge.addr_lo", 32'(RW0_addr), 32'h000);
    cyc(1'b1, 1'b0, 10'h000, 8'h00, 1'b1);
    for (int i = 0; i < 20 && got.size() < 2; i++) begin
      cyc(1'b0, 1'b0, '0, '0, 1'b1);
      if (rsp_valid) got.push_back(rsp_rdata);
    end
    chk("edge.rsp_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("edge.rsp0", 32'(got[0]), 32'hAA);
      chk("edge.rsp1", 32'(got[1]), 32'h55);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
